// File: rtl/stack_sequencer_if.sv
// Bus bundle for the stack sequencer: request/operand inputs, scratch RAM port,
// stack pointer register controls and status outputs.
interface stack_sequencer_if;
    logic       start;
    logic [1:0] op;
    logic [9:0] data_in;
    logic [7:0] sp_in;
    logic [9:0] scr_rd;
    logic [7:0] scr_addr;
    logic [9:0] scr_wd;
    logic       scr_we;
    logic       sp_ld;
    logic       sp_incr;
    logic       sp_decr;
    logic [7:0] sp_data;
    logic [9:0] data_out;
    logic       busy;
    logic       done;
    logic [8:0] depth;
    logic       ovf;
    logic       unf;

    modport master (
        output start, op, data_in, sp_in, scr_rd,
        input  scr_addr, scr_wd, scr_we, sp_ld, sp_incr, sp_decr, sp_data,
        input  data_out, busy, done, depth, ovf, unf
    );

    modport slave (
        input  start, op, data_in, sp_in, scr_rd,
        output scr_addr, scr_wd, scr_we, sp_ld, sp_incr, sp_decr, sp_data,
        output data_out, busy, done, depth, ovf, unf
    );
endinterface

// File: rtl/stack_sequencer.sv
// Push/pop/load sequencer for a descending stack held in scratch RAM, with an
// external stack pointer register, entry depth tracking and sticky OVF/UNF flags.
module stack_sequencer (
    input  logic             CLK,
    input  logic             RST,
    stack_sequencer_if.slave sq
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PUSH    = 3'd1,
        S_POP_RD  = 3'd2,
        S_POP_CAP = 3'd3,
        S_LOAD    = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    localparam logic [8:0] DEPTH_FULL  = 9'd256;
    localparam logic [8:0] DEPTH_EMPTY = 9'd0;

    // The stack grows downward: the new top lives one below the current pointer.
    function automatic logic [7:0] f_push_addr(input logic [7:0] sp);
        return sp - 8'd1;
    endfunction

    state_t     r_state;
    state_t     w_next_state;
    logic       w_set_ovf;
    logic       w_set_unf;

    logic [7:0] w_scr_addr;
    logic [9:0] w_scr_wd;
    logic       w_scr_we;
    logic       w_sp_ld;
    logic       w_sp_incr;
    logic       w_sp_decr;
    logic [7:0] w_sp_data;
    logic       w_done;
    logic       w_busy;

    logic [7:0] r_scr_addr;
    logic [9:0] r_scr_wd;
    logic       r_scr_we;
    logic       r_sp_ld;
    logic       r_sp_incr;
    logic       r_sp_decr;
    logic [7:0] r_sp_data;
    logic       r_done;
    logic       r_busy;
    logic [9:0] r_data_out;
    logic [8:0] r_depth;
    logic       r_ovf;
    logic       r_unf;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; requests are only looked at in IDLE, so nothing queues.
    always_comb begin
        w_next_state = r_state;
        w_set_ovf    = 1'b0;
        w_set_unf    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sq.start) begin
                    case (sq.op)
                        OP_PUSH: begin
                            if (r_depth == DEPTH_FULL) begin
                                w_set_ovf    = 1'b1;
                                w_next_state = S_FIN;
                            end else begin
                                w_next_state = S_PUSH;
                            end
                        end
                        OP_POP: begin
                            if (r_depth == DEPTH_EMPTY) begin
                                w_set_unf    = 1'b1;
                                w_next_state = S_FIN;
                            end else begin
                                w_next_state = S_POP_RD;
                            end
                        end
                        OP_LOAD: begin
                            w_next_state = S_LOAD;
                        end
                        default: begin
                            w_next_state = S_IDLE;
                        end
                    endcase
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_PUSH:    w_next_state = S_FIN;
            S_POP_RD:  w_next_state = S_POP_CAP;
            S_POP_CAP: w_next_state = S_FIN;
            S_LOAD:    w_next_state = S_FIN;
            S_FIN:     w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Output values for the state being entered; registered below so each
    // output is glitch-free and aligned with the state it belongs to.
    always_comb begin
        w_scr_addr = 8'd0;
        w_scr_wd   = 10'd0;
        w_scr_we   = 1'b0;
        w_sp_ld    = 1'b0;
        w_sp_incr  = 1'b0;
        w_sp_decr  = 1'b0;
        w_sp_data  = 8'd0;
        w_done     = 1'b0;
        w_busy     = (w_next_state != S_IDLE);
        case (w_next_state)
            S_PUSH: begin
                w_scr_addr = f_push_addr(sq.sp_in);
                w_scr_wd   = sq.data_in;
                w_scr_we   = 1'b1;
                w_sp_decr  = 1'b1;
            end
            S_POP_RD: begin
                w_scr_addr = sq.sp_in;
            end
            S_POP_CAP: begin
                w_sp_incr = 1'b1;
            end
            S_LOAD: begin
                w_sp_ld   = 1'b1;
                w_sp_data = sq.data_in[7:0];
            end
            S_FIN: begin
                w_done = 1'b1;
            end
            default: begin
                w_done = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_scr_addr <= 8'd0;
            r_scr_wd   <= 10'd0;
            r_scr_we   <= 1'b0;
            r_sp_ld    <= 1'b0;
            r_sp_incr  <= 1'b0;
            r_sp_decr  <= 1'b0;
            r_sp_data  <= 8'd0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_scr_addr <= w_scr_addr;
            r_scr_wd   <= w_scr_wd;
            r_scr_we   <= w_scr_we;
            r_sp_ld    <= w_sp_ld;
            r_sp_incr  <= w_sp_incr;
            r_sp_decr  <= w_sp_decr;
            r_sp_data  <= w_sp_data;
            r_done     <= w_done;
            r_busy     <= w_busy;
        end
    end

    // Depth counter, popped-data capture and sticky error flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_depth    <= 9'd0;
            r_data_out <= 10'd0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            case (r_state)
                S_PUSH:    r_depth <= r_depth + 9'd1;
                S_POP_CAP: r_depth <= r_depth - 9'd1;
                S_LOAD:    r_depth <= 9'd0;
                default:   r_depth <= r_depth;
            endcase
            if (r_state == S_POP_CAP) begin
                r_data_out <= sq.scr_rd;
            end else begin
                r_data_out <= r_data_out;
            end
            r_ovf <= r_ovf | w_set_ovf;
            r_unf <= r_unf | w_set_unf;
        end
    end

    assign sq.scr_addr = r_scr_addr;
    assign sq.scr_wd   = r_scr_wd;
    assign sq.scr_we   = r_scr_we;
    assign sq.sp_ld    = r_sp_ld;
    assign sq.sp_incr  = r_sp_incr;
    assign sq.sp_decr  = r_sp_decr;
    assign sq.sp_data  = r_sp_data;
    assign sq.data_out = r_data_out;
    assign sq.busy     = r_busy;
    assign sq.done     = r_done;
    assign sq.depth    = r_depth;
    assign sq.ovf      = r_ovf;
    assign sq.unf      = r_unf;
endmodule
